// File: rtl/seg7_frame_rx_if.sv
// seg7_frame_rx_if
//   Bundles the serial segment input and the decoded-digit output
//   handshake of seg7_frame_rx.
//
//   Serial side : in_bit, in_valid, in_sof (to receiver), in_ready (from receiver)
//   Output side : out_bcd[7:0], out_blank[1:0], out_err[1:0], out_valid,
//                 sync_err, frame_cnt[7:0] (from receiver), out_ready (to receiver)
//
//   modport slave  : the receiver itself
//   modport master : whoever drives bits and consumes frames
interface seg7_frame_rx_if;
  logic       in_bit;
  logic       in_valid;
  logic       in_sof;
  logic       in_ready;
  logic [7:0] out_bcd;
  logic [1:0] out_blank;
  logic [1:0] out_err;
  logic       out_valid;
  logic       out_ready;
  logic       sync_err;
  logic [7:0] frame_cnt;

  modport slave (
    input  in_bit, in_valid, in_sof, out_ready,
    output in_ready, out_bcd, out_blank, out_err, out_valid, sync_err, frame_cnt
  );

  modport master (
    output in_bit, in_valid, in_sof, out_ready,
    input  in_ready, out_bcd, out_blank, out_err, out_valid, sync_err, frame_cnt
  );
endinterface

// File: rtl/seg7_frame_rx.sv
// seg7_frame_rx
//   Receives serialized frames of two active-low seven-segment codes
//   (tens first, then units; each code sent g..a, bit 6 first) and
//   presents the recovered BCD digits on a valid/ready handshake.
//
//   Ports:
//     clk    : system clock, rising edge
//     reset  : asynchronous, active-high reset
//     bus    : seg7_frame_rx_if.slave
//              in_bit/in_valid/in_sof in, in_ready out (= !out_valid)
//              out_bcd {tens,units}, out_blank, out_err, out_valid out,
//              out_ready in, sync_err pulse out, frame_cnt out
module seg7_frame_rx (
  input  logic           clk,
  input  logic           reset,
  seg7_frame_rx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  // Holds the first 13 bits of a frame; the 14th bit is taken straight
  // from in_bit into the decoder, so it never needs to be stored.
  logic [12:0] frame_reg;
  logic [3:0]  bit_cnt_reg;
  logic [7:0]  bcd_reg;
  logic [1:0]  blank_reg;
  logic [1:0]  err_reg;
  logic        sync_err_reg;
  logic [7:0]  frame_cnt_reg;

  logic        out_valid_int;
  logic        in_ready_int;
  logic        accept;
  logic        handshake;
  logic        last_bit;
  logic [13:0] frame_full;
  logic [5:0]  tens_dec;
  logic [5:0]  units_dec;

  // Returns {err, blank, digit}. Matching is exact on all seven bits.
  function automatic logic [5:0] decode_seg(input logic [6:0] code);
    logic [5:0] res;
    case (code)
      7'h40:   res = {2'b00, 4'd0};
      7'h79:   res = {2'b00, 4'd1};
      7'h24:   res = {2'b00, 4'd2};
      7'h30:   res = {2'b00, 4'd3};
      7'h19:   res = {2'b00, 4'd4};
      7'h12:   res = {2'b00, 4'd5};
      7'h02:   res = {2'b00, 4'd6};
      7'h78:   res = {2'b00, 4'd7};
      7'h00:   res = {2'b00, 4'd8};
      7'h10:   res = {2'b00, 4'd9};
      7'h7F:   res = {2'b01, 4'hF};
      default: res = {2'b10, 4'hF};
    endcase
    return res;
  endfunction

  // Handshake qualifiers.
  assign accept     = bus.in_valid && in_ready_int;
  assign handshake  = out_valid_int && bus.out_ready;
  assign last_bit   = (state_reg == SHIFT) && !bus.in_sof && (bit_cnt_reg == 4'd13);
  assign frame_full = {frame_reg, bus.in_bit};
  assign tens_dec   = decode_seg(frame_full[13:7]);
  assign units_dec  = decode_seg(frame_full[6:0]);

  // FSM: state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic. A mid-frame in_sof keeps the FSM in SHIFT;
  // the datapath restarts the frame.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && bus.in_sof) state_next = SHIFT;
      SHIFT:   if (accept && last_bit)   state_next = HOLD;
      HOLD:    if (handshake)            state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs. out_valid is exactly the HOLD state, so in_ready
  // drops in the same cycle the decoded frame appears.
  always_comb begin
    out_valid_int = (state_reg == HOLD);
    in_ready_int  = !out_valid_int;
  end

  // Datapath: bit capture, decode load, resync pulse and frame counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_reg     <= '0;
      bit_cnt_reg   <= '0;
      bcd_reg       <= '0;
      blank_reg     <= '0;
      err_reg       <= '0;
      sync_err_reg  <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      sync_err_reg <= 1'b0;
      if (accept && bus.in_sof) begin
        // Start (or restart) a frame with this bit as bit 0.
        frame_reg    <= {12'd0, bus.in_bit};
        bit_cnt_reg  <= 4'd1;
        sync_err_reg <= (state_reg == SHIFT);
      end else if (accept && (state_reg == SHIFT)) begin
        frame_reg <= frame_full[12:0];
        if (last_bit) begin
          bit_cnt_reg <= 4'd0;
          bcd_reg     <= {tens_dec[3:0], units_dec[3:0]};
          blank_reg   <= {tens_dec[4], units_dec[4]};
          err_reg     <= {tens_dec[5], units_dec[5]};
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
      end
      if (handshake) begin
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.out_bcd   = bcd_reg;
  assign bus.out_blank = blank_reg;
  assign bus.out_err   = err_reg;
  assign bus.sync_err  = sync_err_reg;
  assign bus.frame_cnt = frame_cnt_reg;

endmodule
